tdm_mul_sat: RTL
================

TDM_MUL_SAT -- requirements
Module: tdm_mul_sat

Interface
REQ-001 SHALL take parameter C_WIDTH, default 32, operand/product width in bits.
REQ-002 SHALL take parameter FIXED_POINT, default 8, fractional bits of every operand and product.
REQ-003 SHALL take parameter NUM_UNITS, default 8, channel count (>=2).
REQ-004 SHALL take parameter SIGNED, default 0; 0 = unsigned, 1 = two's-complement arithmetic.
REQ-005 SHALL have port ctl_clk  input  1  sole clock, rising-edge.
REQ-006 SHALL have port ctl_rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-007 SHALL have port start  input  1  frame request pulse.
REQ-008 SHALL have port multiplicands  input  C_WIDTH*NUM_UNITS  channel i at bits [C_WIDTH*(i+1)-1 : C_WIDTH*i].
REQ-009 SHALL have port multipliers  input  C_WIDTH*NUM_UNITS  same packing.
REQ-010 SHALL have port products  output  C_WIDTH*NUM_UNITS  registered results, same packing.
REQ-011 SHALL have port overflow  output  NUM_UNITS  per-channel saturation flag, bit i = channel i.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port done  output  1  one-cycle frame-complete pulse.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> IDLE, using exactly one shared multiplier.
REQ-015 IDLE: start=1 at edge E0 SHALL snapshot all operands into internal registers, set busy, enter ISSUE with channel index 0.
REQ-016 ISSUE SHALL feed channel index k to the multiplier on edge E0+1+k, k = 0..NUM_UNITS-1, in ascending order, then enter DRAIN.
REQ-017 Multiplier path SHALL be two register stages: stage 1 = full 2*C_WIDTH product; stage 2 = shifted/saturated C_WIDTH result written to the result buffer for its channel.
REQ-018 DRAIN SHALL last 2 cycles; at edge E0+NUM_UNITS+2, products and overflow SHALL update together from the result buffer, done SHALL pulse high for one cycle, busy SHALL drop, state SHALL return to IDLE.
REQ-019 products/overflow SHALL hold their previous values between frames; no partial frame SHALL ever be visible.
REQ-020 Scaling: full product SHALL be shifted right by FIXED_POINT (arithmetic shift if SIGNED=1, logical if SIGNED=0), i.e. truncation toward minus infinity.
REQ-021 Saturation: shifted value above max SHALL give max (unsigned 2^C_WIDTH-1; signed 2^(C_WIDTH-1)-1); below signed min SHALL give -2^(C_WIDTH-1); overflow[i]=1 in either case, else 0.
REQ-022 start while busy SHALL be ignored, with no effect on the running frame or the snapshot.
REQ-023 start in the same cycle done is high SHALL be accepted (FSM already IDLE), giving back-to-back frames every NUM_UNITS+2 cycles.
REQ-024 Operand changes after E0 SHALL NOT affect the running frame.

Reset
REQ-025 ctl_rst=1 at a rising edge SHALL force IDLE and clear products, overflow, busy, done, the snapshot, the result buffer and the pipeline to 0.
REQ-026 Reset mid-frame SHALL abort the frame; no done pulse SHALL follow for it.
REQ-027 start asserted together with ctl_rst SHALL be ignored.

Verification (C_WIDTH=32, FIXED_POINT=8, NUM_UNITS=8)
REQ-028 SIGNED=0, all channels a=0x00000300, b=0x00000200, start pulse -> done exactly 10 cycles after start edge; every product 0x00000600; overflow=0x00.
REQ-029 SIGNED=0, ch3 a=b=0x7FFFFFFF, others a=0x7FFFFFFF, b=0x7F -> ch3 product 0xFFFFFFFF, overflow=0x08; other channels 0x3F7FFFFF.
REQ-030 SIGNED=1, ch0 a=0xFFFFFD00, b=0x200 -> 0xFFFFFA00; ch1 a=0x7FFFFFFF, b=0x200 -> 0x7FFFFFFF, overflow bit1=1; ch2 a=0x80000000, b=0x200 -> 0x80000000, overflow bit2=1.
REQ-031 Channel i a=(i+1)<<8, b=0x100; operands changed and start re-pulsed 3 cycles after E0 -> products (i+1)<<8 with no second done; a start coincident with done -> second done exactly 10 cycles later.
REQ-032 ctl_rst pulsed 4 cycles after start -> busy=0 next cycle, products all 0, no done for 20 cycles; a fresh start then completes normally.

Source files
------------

// File: rtl/tdm_mul_sat.sv
// Time-multiplexed fixed-point multiplier: one shared multiplier serves NUM_UNITS channels per frame.
// Results are shifted by FIXED_POINT and saturated, then published all at once when the frame completes.
module tdm_mul_sat #(
    parameter int C_WIDTH     = 32,
    parameter int FIXED_POINT = 8,
    parameter int NUM_UNITS   = 8,
    parameter int SIGNED      = 0
) (
    input  logic                           ctl_clk,
    input  logic                           ctl_rst,
    input  logic                           start,
    input  logic [C_WIDTH*NUM_UNITS-1:0]   multiplicands,
    input  logic [C_WIDTH*NUM_UNITS-1:0]   multipliers,
    output logic [C_WIDTH*NUM_UNITS-1:0]   products,
    output logic [NUM_UNITS-1:0]           overflow,
    output logic                           busy,
    output logic                           done
);
    localparam int W   = C_WIDTH;
    localparam int PW  = 2 * C_WIDTH;
    localparam int IW  = $clog2(NUM_UNITS);
    localparam bit SGN = (SIGNED != 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic                   r_drain;
    logic [W*NUM_UNITS-1:0] r_a;
    logic [W*NUM_UNITS-1:0] r_b;
    logic [PW-1:0]          r_p1;
    logic                   r_p1_vld;
    logic [IW-1:0]          r_p1_ch;
    logic [W*NUM_UNITS-1:0] r_res;
    logic [NUM_UNITS-1:0]   r_res_ovf;
    logic [W*NUM_UNITS-1:0] r_products;
    logic [NUM_UNITS-1:0]   r_overflow;
    logic                   r_busy;
    logic                   r_done;

    logic [W-1:0]           w_op_a;
    logic [W-1:0]           w_op_b;
    logic [PW-1:0]          w_ax;
    logic [PW-1:0]          w_bx;
    logic [PW-1:0]          w_prod;
    logic signed [PW-1:0]   w_sh_s;
    logic [PW-1:0]          w_sh_u;
    logic [PW-1:0]          w_sh;
    logic [W-1:0]           w_sat;
    logic                   w_ovf;

    assign w_op_a = r_a[r_idx*W +: W];
    assign w_op_b = r_b[r_idx*W +: W];

    // Extending both operands to PW bits makes the low PW product bits correct for either signedness.
    assign w_ax   = {{W{SGN & w_op_a[W-1]}}, w_op_a};
    assign w_bx   = {{W{SGN & w_op_b[W-1]}}, w_op_b};
    assign w_prod = w_ax * w_bx;

    assign w_sh_s = $signed(r_p1) >>> FIXED_POINT;
    assign w_sh_u = r_p1 >> FIXED_POINT;
    assign w_sh   = SGN ? w_sh_s : w_sh_u;

    always_comb begin
        w_sat = w_sh[W-1:0];
        w_ovf = 1'b0;
        if (SGN) begin
            // Representable only when the top W+1 bits are a pure sign extension.
            if (w_sh[PW-1:W-1] != {(W+1){w_sh[PW-1]}}) begin
                w_ovf = 1'b1;
                w_sat = w_sh[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            end
        end else if (|w_sh[PW-1:W]) begin
            w_ovf = 1'b1;
            w_sat = '1;
        end
    end

    always_ff @(posedge ctl_clk) begin
        if (ctl_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_drain    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_p1       <= '0;
            r_p1_vld   <= 1'b0;
            r_p1_ch    <= '0;
            r_res      <= '0;
            r_res_ovf  <= '0;
            r_products <= '0;
            r_overflow <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_p1_vld <= 1'b0;
            if (r_p1_vld) begin
                r_res[r_p1_ch*W +: W] <= w_sat;
                r_res_ovf[r_p1_ch]    <= w_ovf;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= multiplicands;
                        r_b     <= multipliers;
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_p1     <= w_prod;
                    r_p1_vld <= 1'b1;
                    r_p1_ch  <= r_idx;
                    if (r_idx == IW'(NUM_UNITS - 1)) begin
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Second drain cycle: last channel has landed in the buffer, publish the whole frame.
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_products <= r_res;
                        r_overflow <= r_res_ovf;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign products = r_products;
    assign overflow = r_overflow;
    assign busy     = r_busy;
    assign done     = r_done;
endmodule
